// File: rtl/aes_bridge_pkg.sv
// Shared types and sizes for the AES word bridge: 32-bit words packed into 128-bit blocks.
// Also provides word selection within a block, MSB word first.
package aes_bridge_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int CNT_W           = 3;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;

    // Index 0 is the most significant word, matching the write/read order.
    function automatic word_t block_word(input block_t blk, input logic [1:0] idx);
        word_t w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_word_bridge_if.sv
// Word-stream, core-side and status signals of the AES word bridge.
// The slave modport is the bridge's view; master is the environment's view.
interface aes_word_bridge_if;
    import aes_bridge_pkg::*;

    logic   AES_wr_valid;
    logic   AES_wr_ready;
    logic   AES_wr_sel;
    word_t  AES_wr_data;
    logic   AES_rd_valid;
    logic   AES_rd_ready;
    word_t  AES_rd_data;
    logic   AES_core_en;
    block_t AES_core_data;
    block_t AES_core_key;
    logic   AES_core_valid;
    block_t AES_core_out;
    logic   AES_busy;
    logic   AES_err;
    logic   AES_err_clr;

    modport slave (
        input  AES_wr_valid, AES_wr_sel, AES_wr_data, AES_rd_ready,
               AES_core_valid, AES_core_out, AES_err_clr,
        output AES_wr_ready, AES_rd_valid, AES_rd_data, AES_core_en,
               AES_core_data, AES_core_key, AES_busy, AES_err
    );

    modport master (
        output AES_wr_valid, AES_wr_sel, AES_wr_data, AES_rd_ready,
               AES_core_valid, AES_core_out, AES_err_clr,
        input  AES_wr_ready, AES_rd_valid, AES_rd_data, AES_core_en,
               AES_core_data, AES_core_key, AES_busy, AES_err
    );

endinterface

// File: rtl/aes_word_packer.sv
// Shifts 32-bit words into a 128-bit block, MSB word first; one word per cycle, no backpressure of its own.
// WRAP=1: count wraps mod 4, full cleared on first word of a new block. WRAP=0: count saturates at 4.
module aes_word_packer
    import aes_bridge_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   shift,
    input  logic   clr,
    input  word_t  din,
    output block_t blk,
    output logic   full
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(WORDS_PER_BLOCK);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk  <= '0;
            cnt  <= '0;
            full <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            full <= 1'b0;
        end else if (shift) begin
            blk <= {blk[BLOCK_W-WORD_W-1:0], din};
            if (WRAP) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                if (cnt == LAST)
                    full <= 1'b1;
                else if (cnt == '0)
                    full <= 1'b0;
            end else begin
                // Surplus words keep shifting so the newest four form the block.
                if (cnt != SAT)
                    cnt <= cnt + 1'b1;
                if (cnt >= LAST)
                    full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_word_bridge.sv
// Word front/back end for AES_top: packs key/data words, runs one block, returns 4 ciphertext words.
// Start 2 cycles after the completing write; input stalls outside LOAD, output holds under rd_ready=0.
module aes_word_bridge
    import aes_bridge_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic              AES_clk,
    input  logic              AES_rst_n,
    aes_word_bridge_if.slave  bus
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state;
    logic              start_pend;
    logic [TO_W-1:0]   to_cnt;
    logic [1:0]        idx;
    block_t            result;
    block_t            key_blk;
    block_t            data_blk;
    logic              key_ok;
    logic              data_full;
    logic              core_en;
    logic              rd_valid;
    word_t             rd_data;
    logic              err;

    logic              wr_ready;
    logic              key_shift;
    logic              data_shift;
    logic              data_clr;
    logic              timeout;

    // Writes stop as soon as a complete key and data block are registered.
    assign wr_ready   = (state == LOAD) && !start_pend && !(key_ok && data_full);
    assign key_shift  = bus.AES_wr_valid && wr_ready && bus.AES_wr_sel;
    assign data_shift = bus.AES_wr_valid && wr_ready && !bus.AES_wr_sel;
    assign timeout    = (state == RUN) && !bus.AES_core_valid && (to_cnt == TO_LAST);
    assign data_clr   = ((state == LOAD) && start_pend) || timeout;

    aes_word_packer #(.WRAP(1'b1)) u_key_packer (
        .clk   (AES_clk),
        .rst_n (AES_rst_n),
        .shift (key_shift),
        .clr   (1'b0),
        .din   (bus.AES_wr_data),
        .blk   (key_blk),
        .full  (key_ok)
    );

    aes_word_packer #(.WRAP(1'b0)) u_data_packer (
        .clk   (AES_clk),
        .rst_n (AES_rst_n),
        .shift (data_shift),
        .clr   (data_clr),
        .din   (bus.AES_wr_data),
        .blk   (data_blk),
        .full  (data_full)
    );

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state      <= LOAD;
            start_pend <= 1'b0;
            to_cnt     <= '0;
            idx        <= '0;
            result     <= '0;
            core_en    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            err        <= 1'b0;
        end else begin
            // A timeout in the same cycle as a clear request leaves the flag set.
            if (timeout)
                err <= 1'b1;
            else if (bus.AES_err_clr)
                err <= 1'b0;

            case (state)
                LOAD: begin
                    if (start_pend) begin
                        start_pend <= 1'b0;
                        state      <= RUN;
                        core_en    <= 1'b1;
                        to_cnt     <= '0;
                    end else if (key_ok && data_full) begin
                        start_pend <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.AES_core_valid) begin
                        result   <= bus.AES_core_out;
                        core_en  <= 1'b0;
                        rd_valid <= 1'b1;
                        rd_data  <= block_word(bus.AES_core_out, 2'd0);
                        idx      <= 2'd0;
                        state    <= DRAIN;
                    end else if (timeout) begin
                        core_en  <= 1'b0;
                        state    <= LOAD;
                    end else begin
                        to_cnt   <= to_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (rd_valid && bus.AES_rd_ready) begin
                        if (idx == 2'd3) begin
                            rd_valid <= 1'b0;
                            state    <= LOAD;
                        end else begin
                            idx     <= idx + 2'd1;
                            rd_data <= block_word(result, idx + 2'd1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.AES_wr_ready  = wr_ready;
    assign bus.AES_rd_valid  = rd_valid;
    assign bus.AES_rd_data   = rd_data;
    assign bus.AES_core_en   = core_en;
    assign bus.AES_core_data = data_blk;
    assign bus.AES_core_key  = key_blk;
    assign bus.AES_busy      = (state != LOAD);
    assign bus.AES_err       = err;

endmodule

// File: tb/tb_aes_word_bridge.sv
// Randomized scoreboard bench for aes_word_bridge with a stub AES core (out = data ^ key).
module tb_aes_word_bridge;
    import aes_bridge_pkg::*;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_word_bridge_if bus();

    aes_word_bridge #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
        .AES_clk   (clk),
        .AES_rst_n (rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: words written since reset / since the last block start.
    word_t        m_key[$];
    int           m_key_total = 0;
    word_t        m_data[$];
    logic [31:0]  exp_q[$];

    logic stall = 1'b1;
    logic stub_on = 1'b1;
    int   stub_delay = 10;
    int   en_run = 0;
    int   last_en_len = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic block_t last4(input word_t q[$]);
        int n = q.size();
        return {q[n-4], q[n-3], q[n-2], q[n-1]};
    endfunction

    // Stub core: raises valid on the stub_delay-th cycle of enable.
    always @(posedge clk) begin
        #1;
        if (bus.AES_core_en) begin
            en_run++;
            bus.AES_core_valid = stub_on && (en_run == stub_delay);
            bus.AES_core_out   = bus.AES_core_data ^ bus.AES_core_key;
        end else begin
            if (en_run != 0) last_en_len = en_run;
            en_run = 0;
            bus.AES_core_valid = 1'b0;
            bus.AES_core_out   = '0;
        end
    end

    always @(posedge clk) begin
        #1;
        bus.AES_rd_ready = !stall && ($urandom_range(0, 3) != 0);
    end

    // Monitor: every output handshake is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.AES_rd_valid && bus.AES_rd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h expected no word", bus.AES_rd_data);
            end else begin
                check("rd_word", bus.AES_rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic wr(input logic sel, input word_t d);
        int t = 0;
        bus.AES_wr_valid = 1'b1;
        bus.AES_wr_sel   = sel;
        bus.AES_wr_data  = d;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.AES_wr_ready && t < 200);
        check("wr_handshake", bus.AES_wr_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.AES_wr_valid = 1'b0;
        if (sel) begin
            m_key.push_back(d);
            m_key_total++;
        end else begin
            m_data.push_back(d);
        end
    endtask

    task automatic write_key(input block_t k);
        for (int i = 0; i < 4; i++) wr(1'b1, k[127 - 32*i -: 32]);
    endtask

    task automatic write_data(input block_t d);
        for (int i = 0; i < 4; i++) wr(1'b0, d[127 - 32*i -: 32]);
    endtask

    task automatic expect_block();
        block_t b = last4(m_data) ^ last4(m_key);
        for (int i = 0; i < 4; i++) exp_q.push_back(b[127 - 32*i -: 32]);
        m_data.delete();
    endtask

    // Called right after the completing write's edge: enable must rise two edges later.
    task automatic check_latency();
        @(negedge clk);
        check("lat_en_n1", bus.AES_core_en, 1'b0);
        check("lat_wr_ready_start", bus.AES_wr_ready, 1'b0);
        @(negedge clk);
        check("lat_en_n2", bus.AES_core_en, 1'b0);
        @(negedge clk);
        check("lat_en_n3", bus.AES_core_en, 1'b1);
        check("lat_busy", bus.AES_busy, 1'b1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((bus.AES_busy || exp_q.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", (t < 1000), 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_block(output block_t b);
        b = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        block_t b;
        block_t k;
        int t;
        int extra;

        bus.AES_wr_valid = 1'b0;
        bus.AES_wr_sel   = 1'b0;
        bus.AES_wr_data  = '0;
        bus.AES_err_clr  = 1'b0;

        #12;
        check("rst_wr_ready", bus.AES_wr_ready, 1'b1);
        check("rst_busy", bus.AES_busy, 1'b0);
        check("rst_err", bus.AES_err, 1'b0);
        check("rst_core_en", bus.AES_core_en, 1'b0);
        check("rst_rd_valid", bus.AES_rd_valid, 1'b0);
        check("rst_rd_data", bus.AES_rd_data, 32'h0);
        check("rst_core_data", bus.AES_core_data, 128'h0);
        check("rst_core_key", bus.AES_core_key, 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stall = 1'b0;
        @(posedge clk);
        #1;

        // Basic block
        stub_delay = 10;
        write_key(128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
        write_data(128'h000000d9_00000000_00000000_00000000);
        expect_block();
        check_latency();
        wait_idle();
        check("basic_en_len", last_en_len, 10);
        check("basic_err", bus.AES_err, 1'b0);

        // Same key, new data only
        write_data(128'ha6f2daeb_140fa720_529e75d5_21cbc681);
        expect_block();
        wait_idle();

        // Output backpressure
        stall = 1'b1;
        rand_block(b);
        write_data(b);
        expect_block();
        t = 0;
        while (!bus.AES_rd_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("bp_rd_valid_seen", bus.AES_rd_valid, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_rd_valid_hold", bus.AES_rd_valid, 1'b1);
            check("bp_rd_data_hold", bus.AES_rd_data, exp_q[0]);
        end
        stall = 1'b0;
        wait_idle();
        check("bp_back_to_load", bus.AES_busy, 1'b0);

        // Random blocks, some with a new key interleaved with surplus data words
        for (int it = 0; it < 8; it++) begin
            stub_delay = $urandom_range(1, 20);
            rand_block(b);
            if ($urandom_range(0, 1) == 1) begin
                rand_block(k);
                extra = $urandom_range(0, 2);
                wr(1'b1, k[127:96]);
                for (int j = 0; j < extra; j++) wr(1'b0, $urandom);
                write_data(b);
                wr(1'b1, k[95:64]);
                wr(1'b1, k[63:32]);
                wr(1'b1, k[31:0]);
            end else begin
                write_data(b);
            end
            expect_block();
            check_latency();
            wait_idle();
            check("rand_en_len", last_en_len, stub_delay);
        end

        // Timeout: stub never answers
        stub_on = 1'b0;
        rand_block(b);
        write_data(b);
        m_data.delete();
        t = 0;
        while (!bus.AES_core_en && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("to_en_rise", bus.AES_core_en, 1'b1);
        t = 0;
        while (bus.AES_core_en && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("to_en_fall", bus.AES_core_en, 1'b0);
        check("to_en_len", last_en_len, TIMEOUT);
        check("to_err_set", bus.AES_err, 1'b1);
        check("to_busy", bus.AES_busy, 1'b0);
        check("to_rd_valid", bus.AES_rd_valid, 1'b0);
        @(posedge clk);
        #1;
        bus.AES_err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.AES_err_clr = 1'b0;
        @(negedge clk);
        check("to_err_clr", bus.AES_err, 1'b0);
        stub_on = 1'b1;
        stub_delay = 5;
        // Discarded data: one new word must not start a block
        rand_block(b);
        @(posedge clk);
        #1;
        wr(1'b0, b[127:96]);
        repeat (4) @(negedge clk);
        check("to_data_discarded", bus.AES_core_en, 1'b0);
        @(posedge clk);
        #1;
        wr(1'b0, b[95:64]);
        wr(1'b0, b[63:32]);
        wr(1'b0, b[31:0]);
        expect_block();
        wait_idle();

        // Asynchronous reset in the middle of RUN
        stub_on = 1'b0;
        rand_block(b);
        write_data(b);
        m_data.delete();
        t = 0;
        while (en_run < 5 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("ar_en_before", bus.AES_core_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_core_en", bus.AES_core_en, 1'b0);
        check("ar_busy", bus.AES_busy, 1'b0);
        check("ar_rd_valid", bus.AES_rd_valid, 1'b0);
        check("ar_wr_ready", bus.AES_wr_ready, 1'b1);
        m_key.delete();
        m_key_total = 0;
        m_data.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stub_on = 1'b1;
        stub_delay = 7;

        // Data before key: no start until the key is reloaded
        rand_block(b);
        write_data(b);
        repeat (6) @(negedge clk);
        check("dbk_no_start", bus.AES_core_en, 1'b0);
        check("dbk_not_busy", bus.AES_busy, 1'b0);
        @(posedge clk);
        #1;
        rand_block(k);
        write_key(k);
        expect_block();
        check_latency();
        wait_idle();
        check("dbk_en_len", last_en_len, 7);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_word_bridge.md
Name: aes_word_bridge

Overview:
- 32-bit word-stream front/back end for AES_top: assembles 128-bit key and plaintext from 32-bit writes, drives AES_en/AES_data_in/AES_key_in, captures AES_data_out on AES_data_out_valid, returns ciphertext as four 32-bit words.
- Sits directly upstream and downstream of AES_top; one block in flight at a time.

Parameters:
- TIMEOUT, 64, max cycles in RUN waiting for core valid before abort (≥2).
- TO_W, 7, width of timeout counter (holds TIMEOUT).

Ports:
- AES_clk  in  1  clock, rising edge
- AES_rst_n  in  1  asynchronous, active-low reset
- AES_wr_valid  in  1  input word valid
- AES_wr_ready  out  1  input word accepted when valid&ready
- AES_wr_sel  in  1  1=key word, 0=data word
- AES_wr_data  in  32  word, MSB word first
- AES_rd_valid  out  1  output word valid
- AES_rd_ready  in  1  output word consumed when valid&ready
- AES_rd_data  out  32  ciphertext word, MSB word first
- AES_core_en  out  1  to AES_top AES_en
- AES_core_data  out  128  to AES_top AES_data_in
- AES_core_key  out  128  to AES_top AES_key_in
- AES_core_valid  in  1  from AES_top AES_data_out_valid
- AES_core_out  in  128  from AES_top AES_data_out
- AES_busy  out  1  state != LOAD
- AES_err  out  1  sticky timeout flag
- AES_err_clr  in  1  clears AES_err

Behaviour:
- Reset (async, AES_rst_n=0): state LOAD; key/data/result registers 0; key_cnt=data_cnt=0; key_ok=0; AES_core_en=0, AES_rd_valid=0, AES_err=0, AES_rd_data=0. AES_core_data/AES_core_key are direct register outputs (0 after reset).
- LOAD: AES_wr_ready=1. Key write: key_reg={key_reg[95:0],wr_data}; key_cnt+1 mod 4; key_ok cleared on the first word of a new key (key_cnt==0) and set on the 4th. Data write: same shift into data_reg; data_cnt saturates at 4; extra data words shift in, count stays 4.
- Start: first cycle in LOAD with key_ok=1 and data_cnt==4 (evaluated on registered values) -> RUN next edge, AES_core_en=1 registered, data_cnt=0. AES_wr_ready=0 in that start cycle.
- RUN: AES_wr_ready=0; AES_core_en held 1; to_cnt increments from 0. First cycle AES_core_valid=1: result_reg<=AES_core_out, AES_core_en<=0, -> DRAIN, word index 0. If to_cnt reaches TIMEOUT-1 without valid: AES_core_en<=0, AES_err<=1, -> LOAD; key retained, data discarded.
- DRAIN: AES_rd_valid=1, AES_rd_data=result word[idx] (idx0=[127:96]). On rd_valid&rd_ready idx+1; after 4th handshake -> LOAD, rd_valid=0 next cycle. rd_data stable while stalled. AES_core_valid ignored outside RUN.
- Key persists across blocks; new data alone restarts encryption.
- Simultaneous wr_sel key write completing the 4th key word while data_cnt==4: start evaluated next cycle (registered key_ok).
- AES_err_clr has priority over setting in the same cycle? No: set wins; clear applies only when no timeout that cycle.
- Reset mid-RUN/DRAIN: immediate return to reset values, result lost, AES_core_en drops asynchronously.
- Latency: last data word accepted at edge N -> AES_core_en=1 after edge N+2; core valid at edge M -> first rd_valid after edge M+1.

Decomposition:
- Package aes_bridge_pkg: state enum {LOAD, RUN, DRAIN}, word width 32, block width 128, WORDS_PER_BLOCK=4.
- One sub-module natural: aes_word_packer (shift register + saturating count + full flag), instantiated twice for key and data.

Test Plan:
- Basic: key aa2bdb40,bff6a5e8,caa9ba3e,bc1e2acc; data 000000d9,0,0,0; stub core valid 10 cycles after en with out=data^key -> AES_core_en high 10 cycles, rd words aa2bdb99,bff6a5e8,caa9ba3e,bc1e2acc, err=0.
- Key reuse: after basic, data a6f2daeb,140fa720,529e75d5,21cbc681 only -> second encryption with same key, rd = data^key.
- Backpressure: hold AES_rd_ready=0 20 cycles in DRAIN -> rd_valid=1, rd_data=word0 stable; then 4 words in order, state LOAD.
- Timeout: stub never asserts valid -> AES_core_en drops after 64 cycles, AES_err=1, busy=0; AES_err_clr pulse -> err=0.
- Data before key: 4 data words, no key -> no start, en=0; then 4 key words -> start within 2 cycles.
- Async reset mid-RUN (cycle 5) -> core_en, busy, rd_valid 0 immediately; key_ok=0, next block needs full reload.
